delay_seq_ctrl: RTL and testbench
=================================

// Module: delay_seq_ctrl
// PURPOSE
//  Sequencing controller for the programmable digital delay timer. Holds the delay/width
//  configuration, arms on command, detects a rising edge on trig_in, counts the programmed
//  delay and then drives a pulse of programmed width. Sits between the config/host interface
//  and the output pulse pin; the test environment drives it through the timer interface.
// PARAMETERS
//  CNT_W   16  width of delay count (delay range 0 .. 2**CNT_W-1 clk cycles)
//  PW_W    8   width of pulse-width count (width range 1 .. 2**PW_W-1 clk cycles)
// PORTS
//  clk          in   1      single system clock, all logic on rising edge
//  reset        in   1      synchronous, active-high reset
//  cfg_valid    in   1      config write request
//  cfg_ready    out  1      high only in IDLE; write accepted when cfg_valid&&cfg_ready
//  cfg_delay    in   CNT_W  delay D in clk cycles from trigger edge to pulse start
//  cfg_width    in   PW_W   pulse width W in clk cycles (0 treated as 1)
//  cfg_rearm    in   1      1: return to ARMED after pulse; 0: return to IDLE
//  arm          in   1      level; sampled in IDLE only
//  abort        in   1      level; forces IDLE from any state
//  trig_in      in   1      trigger input (synchronous to clk; synchronizer is external)
//  pulse_out    out  1      registered output pulse
//  busy         out  1      high in DELAY or PULSE
//  armed        out  1      high in ARMED
//  done         out  1      1-cycle strobe in the cycle after pulse_out falls
//  err_retrig   out  1      1-cycle strobe: trigger edge seen while busy (edge ignored)
// BEHAVIOUR
//  - Reset: state=IDLE; delay reg=0, width reg=1, rearm reg=0, trig_prev=0; all outputs 0
//    except cfg_ready=1. Reset in any state (incl. mid-pulse) drops pulse_out the next cycle.
//  - States: IDLE, ARMED, DELAY, PULSE. Registered state; outputs decoded from registers.
//  - Edge detect: trig_edge = trig_in && !trig_prev; trig_prev updates every cycle in every
//    state. trig_in already high when arming does not fire; a new rising edge is required.
//  - IDLE: cfg handshake latches delay/width/rearm. arm=1 -> ARMED. arm and cfg write in the
//    same cycle: config latched and ARMED entered; the new config applies.
//  - ARMED: trig_edge at edge N -> D>0: DELAY with cnt=D; D=0: PULSE with pw_cnt=max(W,1).
//  - DELAY: cnt decrements each edge; at cnt==1 -> PULSE, pw_cnt=max(W,1). DELAY lasts
//    exactly D cycles.
//  - PULSE: pulse_out=1; pw_cnt decrements; at pw_cnt==1 -> ARMED if rearm else IDLE; done
//    asserted for the one cycle after the last pulse cycle.
//  - Latency: trig edge sampled at edge N -> pulse_out high from cycle N+1+D for exactly
//    max(W,1) cycles. Back-to-back: with rearm, a new edge sampled the first cycle back in
//    ARMED is honoured.
//  - trig_edge in DELAY/PULSE: ignored, counters undisturbed, err_retrig=1 next cycle.
//  - abort: highest priority (above trig_edge, arm, count expiry). Any state -> IDLE next
//    edge; pulse_out cleared; no done strobe; config registers retained.
//  - cfg_valid outside IDLE: not accepted (cfg_ready=0); registers unchanged.
//  - Counters never wrap: D=2**CNT_W-1 and W=2**PW_W-1 run full length.
// TESTING
//  1 reset; cfg D=5,W=3,rearm=0; arm; trig rise sampled at edge 20 -> pulse_out high cycles
//    26..28, done at 29, state IDLE, cfg_ready=1.
//  2 D=0,W=0 -> pulse_out high exactly 1 cycle, in the cycle after the trigger edge.
//  3 rearm=1, D=2,W=2; two trig edges 10 cycles apart -> two pulses, armed=1 between them;
//    extra edge during DELAY -> err_retrig 1 cycle, pulse timing unchanged.
//  4 abort during PULSE (W=8, 3rd pulse cycle) -> pulse_out 0 next cycle, no done, IDLE;
//    abort and trig_edge in the same cycle in ARMED -> stays IDLE, no pulse.
//  5 cfg_valid with D=7 while busy -> cfg_ready=0, old D used; trig_in held high across
//    arm -> no pulse until it falls and rises again.
//  6 synchronous reset asserted mid-DELAY -> all outputs 0 next cycle; D=0xFFFF, W=0xFF
//    run -> pulse starts exactly 65535 cycles after the edge, lasts 255 cycles.

Source files
------------

// File: rtl/delay_seq_ctrl.sv
// rtl/delay_seq_ctrl.sv - arm/trigger/delay/pulse sequencing controller for the delay timer
module delay_seq_ctrl #(
  parameter int CNT_W = 16,
  parameter int PW_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [CNT_W-1:0] i_cfg_delay,
  input  logic [PW_W-1:0]  i_cfg_width,
  input  logic             i_cfg_rearm,
  input  logic             i_arm,
  input  logic             i_abort,
  input  logic             i_trig_in,
  output logic             o_pulse_out,
  output logic             o_busy,
  output logic             o_armed,
  output logic             o_done,
  output logic             o_err_retrig
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DELAY = 2'd2,
    S_PULSE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PW_W-1:0]  PW_ONE  = PW_W'(1);

  state_t           r_state;
  state_t           w_next_state;

  logic [CNT_W-1:0] r_delay;
  logic [PW_W-1:0]  r_width;
  logic             r_rearm;
  logic             r_trig_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [PW_W-1:0]  r_pw_cnt;
  logic             r_pulse;
  logic             r_done;
  logic             r_err;

  logic             w_trig_edge;
  logic             w_cfg_fire;
  logic [PW_W-1:0]  w_width_eff;
  logic             w_is_busy;
  logic             w_load_delay;
  logic             w_load_pulse;
  logic             w_hold_delay;
  logic             w_hold_pulse;

  // A trigger only counts on a fresh low-to-high transition seen by this block.
  assign w_trig_edge  = i_trig_in && !r_trig_prev;
  assign w_cfg_fire   = i_cfg_valid && (r_state == S_IDLE);
  // A zero width is stored as one so the pulse counter never starts at zero.
  assign w_width_eff  = (i_cfg_width == '0) ? PW_ONE : i_cfg_width;
  assign w_is_busy    = (r_state == S_DELAY) || (r_state == S_PULSE);
  assign w_load_delay = (r_state == S_ARMED) && (w_next_state == S_DELAY);
  assign w_load_pulse = (r_state != S_PULSE) && (w_next_state == S_PULSE);
  assign w_hold_delay = (r_state == S_DELAY) && (w_next_state == S_DELAY);
  assign w_hold_pulse = (r_state == S_PULSE) && (w_next_state == S_PULSE);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; abort outranks every other event in every state.
  always_comb begin
    w_next_state = r_state;
    if (i_abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_arm) begin
            w_next_state = S_ARMED;
          end
        end
        S_ARMED: begin
          if (w_trig_edge) begin
            w_next_state = (r_delay == '0) ? S_PULSE : S_DELAY;
          end
        end
        S_DELAY: begin
          if (r_cnt == CNT_ONE) begin
            w_next_state = S_PULSE;
          end
        end
        S_PULSE: begin
          if (r_pw_cnt == PW_ONE) begin
            w_next_state = r_rearm ? S_ARMED : S_IDLE;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Output decode, driven only from registers.
  always_comb begin
    o_cfg_ready  = (r_state == S_IDLE);
    o_busy       = w_is_busy;
    o_armed      = (r_state == S_ARMED);
    o_pulse_out  = r_pulse;
    o_done       = r_done;
    o_err_retrig = r_err;
  end

  // Configuration registers; writes land only while idle and survive an abort.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_delay <= '0;
      r_width <= PW_ONE;
      r_rearm <= 1'b0;
    end else if (w_cfg_fire) begin
      r_delay <= i_cfg_delay;
      r_width <= w_width_eff;
      r_rearm <= i_cfg_rearm;
    end
  end

  // Previous trigger level, tracked in every state so arming onto a high input does not fire.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_trig_prev <= 1'b0;
    end else begin
      r_trig_prev <= i_trig_in;
    end
  end

  // Delay and width down-counters: loaded on state entry, decremented while the state holds.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_pw_cnt <= '0;
    end else begin
      if (w_load_delay) begin
        r_cnt <= r_delay;
      end else if (w_hold_delay) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
      if (w_load_pulse) begin
        r_pw_cnt <= r_width;
      end else if (w_hold_pulse) begin
        r_pw_cnt <= r_pw_cnt - PW_ONE;
      end
    end
  end

  // Registered pulse, completion strobe and retrigger-error strobe.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pulse <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_pulse <= (w_next_state == S_PULSE);
      r_done  <= !i_abort && (r_state == S_PULSE) && (w_next_state != S_PULSE);
      r_err   <= !i_abort && w_is_busy && w_trig_edge;
    end
  end

endmodule

// File: tb/tb_delay_seq_ctrl.sv
// tb/tb_delay_seq_ctrl.sv - self-checking bench for delay_seq_ctrl
module tb_delay_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_delay;
  logic [7:0]  cfg_width;
  logic        cfg_rearm;
  logic        arm;
  logic        abort;
  logic        trig;
  logic        pulse_out;
  logic        busy;
  logic        armed;
  logic        done;
  logic        err_retrig;

  int checks = 0;
  int errors = 0;

  // Reference model: the controller is idle, armed, or busy with a pulse window
  // [m_start, m_end] measured in edge numbers; everything follows from that window.
  int  k = 0;
  int  m_mode;
  int  m_d;
  int  m_w;
  bit  m_rearm;
  bit  m_prev;
  int  m_start;
  int  m_end;
  int  m_honour;
  bit  m_done;
  bit  m_err;
  logic [5:0] exp_v;
  logic [5:0] obs_v;

  always #5 clk = ~clk;

  delay_seq_ctrl #(.CNT_W(16), .PW_W(8)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_cfg_valid  (cfg_valid),
    .o_cfg_ready  (cfg_ready),
    .i_cfg_delay  (cfg_delay),
    .i_cfg_width  (cfg_width),
    .i_cfg_rearm  (cfg_rearm),
    .i_arm        (arm),
    .i_abort      (abort),
    .i_trig_in    (trig),
    .o_pulse_out  (pulse_out),
    .o_busy       (busy),
    .o_armed      (armed),
    .o_done       (done),
    .o_err_retrig (err_retrig)
  );

  task automatic tick();
    bit e;
    @(posedge clk);
    k++;
    e = trig && !m_prev;
    m_prev = trig;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_mode = 0; m_d = 0; m_w = 1; m_rearm = 1'b0; m_prev = 1'b0;
    end else begin
      if (m_mode == 0 && cfg_valid) begin
        m_d = int'(cfg_delay);
        m_w = (cfg_width == 8'd0) ? 1 : int'(cfg_width);
        m_rearm = cfg_rearm;
      end
      if (abort) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        if (arm) m_mode = 1;
      end else if (m_mode == 1) begin
        if (e) begin
          m_honour = k;
          m_start  = k + m_d;
          m_end    = m_start + m_w - 1;
          m_mode   = 2;
        end
      end else begin
        if (e) m_err = 1'b1;
        if (k == m_end + 1) begin
          m_mode = m_rearm ? 1 : 0;
          m_done = 1'b1;
        end
      end
    end
    #1;
    exp_v = {(m_mode == 2) && (k >= m_start), m_mode == 2, m_mode == 1, m_mode == 0, m_done, m_err};
    obs_v = {pulse_out, busy, armed, cfg_ready, done, err_retrig};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL outs edge=%0d observed(pulse,busy,armed,rdy,done,err)=%b expected=%b", k, obs_v, exp_v);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Trigger must already be set by the caller; the next edge samples it.
  task automatic measure(input string tag, input int off, input int len, input int budget);
    int hon;
    int first;
    int n;
    hon = k + 1;
    first = -1;
    n = 0;
    for (int i = 0; i < budget && first < 0; i++) begin
      tick();
      if (pulse_out) first = k;
    end
    if (first >= 0) begin
      n = 1;
      for (int i = 0; i < len + 4; i++) begin
        tick();
        if (pulse_out) n++;
        else break;
      end
    end
    checks++;
    assert ((first - hon) === off) else begin
      errors++;
      $error("FAIL %s_offset observed=%0d expected=%0d", tag, first - hon, off);
    end
    checks++;
    assert (n === len) else begin
      errors++;
      $error("FAIL %s_width observed=%0d expected=%0d", tag, n, len);
    end
  endtask

  task automatic set_cfg(input int d, input int w, input bit r);
    cfg_valid = 1'b1;
    cfg_delay = d[15:0];
    cfg_width = w[7:0];
    cfg_rearm = r;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_delay = '0; cfg_width = '0; cfg_rearm = 1'b0;
    arm = 1'b0; abort = 1'b0; trig = 1'b0;
    m_mode = 0; m_d = 0; m_w = 1; m_rearm = 1'b0; m_prev = 1'b0;
    m_start = 0; m_end = -1; m_honour = 0;

    // reset state
    ticks(3);
    checks++;
    assert ({pulse_out, busy, armed, cfg_ready, done, err_retrig} === 6'b000100) else begin
      errors++;
      $error("FAIL reset observed=%b expected=%b", {pulse_out, busy, armed, cfg_ready, done, err_retrig}, 6'b000100);
    end
    rst = 1'b0;
    tick();

    // D=5, W=3, one-shot
    set_cfg(5, 3, 1'b0); tick(); cfg_valid = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    ticks(2);
    trig = 1'b1;
    measure("d5w3", 5, 3, 12);
    trig = 1'b0;
    ticks(3);

    // D=0, W=0: single cycle pulse right after the edge; cfg and arm together
    set_cfg(0, 0, 1'b0); arm = 1'b1; tick(); cfg_valid = 1'b0; arm = 1'b0;
    tick();
    trig = 1'b1;
    measure("d0w0", 0, 1, 6);
    trig = 1'b0;
    ticks(3);

    // rearm, D=2, W=2: two pulses, then an extra edge during DELAY
    set_cfg(2, 2, 1'b1); arm = 1'b1; tick(); cfg_valid = 1'b0; arm = 1'b0;
    tick();
    trig = 1'b1;
    measure("rearm1", 2, 2, 8);
    trig = 1'b0;
    ticks(5);
    trig = 1'b1; tick();
    trig = 1'b0; tick();
    trig = 1'b1; tick();
    trig = 1'b0; ticks(6);
    abort = 1'b1; tick(); abort = 1'b0;
    tick();

    // abort on the third pulse cycle, then abort colliding with a trigger edge
    set_cfg(1, 8, 1'b0); arm = 1'b1; tick(); cfg_valid = 1'b0; arm = 1'b0;
    tick();
    trig = 1'b1; tick();
    trig = 1'b0; ticks(3);
    abort = 1'b1; tick(); abort = 1'b0;
    ticks(10);
    arm = 1'b1; tick(); arm = 1'b0;
    tick();
    trig = 1'b1; abort = 1'b1; tick(); abort = 1'b0;
    ticks(4);
    trig = 1'b0;
    ticks(2);

    // cfg write while busy is refused; trigger held high across arm
    set_cfg(3, 2, 1'b0); arm = 1'b1; tick(); cfg_valid = 1'b0; arm = 1'b0;
    tick();
    trig = 1'b1; tick();
    trig = 1'b0; set_cfg(7, 5, 1'b1); ticks(2);
    cfg_valid = 1'b0;
    ticks(6);
    trig = 1'b1; ticks(2);
    arm = 1'b1; tick(); arm = 1'b0;
    ticks(5);
    trig = 1'b0; tick();
    trig = 1'b1;
    measure("old_cfg", 3, 2, 10);
    trig = 1'b0;
    ticks(3);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 149) == 0);
      abort     = ($urandom_range(0, 39) == 0);
      arm       = ($urandom_range(0, 3) == 0);
      cfg_valid = ($urandom_range(0, 4) == 0);
      cfg_delay = 16'($urandom_range(0, 6));
      cfg_width = 8'($urandom_range(0, 4));
      cfg_rearm = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) trig = ~trig;
      tick();
    end
    rst = 1'b0; abort = 1'b0; arm = 1'b0; cfg_valid = 1'b0; trig = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    ticks(2);

    // reset in the middle of DELAY
    set_cfg(4, 3, 1'b0); arm = 1'b1; tick(); cfg_valid = 1'b0; arm = 1'b0;
    tick();
    trig = 1'b1; tick();
    trig = 1'b0; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    assert ({pulse_out, busy, armed, cfg_ready, done, err_retrig} === 6'b000100) else begin
      errors++;
      $error("FAIL mid_reset observed=%b expected=%b", {pulse_out, busy, armed, cfg_ready, done, err_retrig}, 6'b000100);
    end
    ticks(2);

    // full-range counters
    set_cfg(16'hFFFF, 8'hFF, 1'b0); arm = 1'b1; tick(); cfg_valid = 1'b0; arm = 1'b0;
    tick();
    trig = 1'b1;
    measure("full", 65535, 255, 65545);
    trig = 1'b0;
    ticks(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
